// File: rtl/envelope_vca_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : envelope_vca_pkg
//  Description : Shared synth-voice constants used by the tone generator, the
//                ADSR envelope and the envelope VCA, plus a helper that turns a
//                slew-step parameter into the effective per-sample step.
//  Contents    : c_SAMPLE_BITS        - signed audio sample width
//                c_AMP_BITS           - unsigned envelope amplitude width
//                c_SLEW_STEP_DEFAULT  - default amplitude slew per sample
//                clamp_step()         - effective step for a given width
//  Revision    : 1.0 - initial release
// ============================================================================
package envelope_vca_pkg;

    localparam int c_SAMPLE_BITS       = 16;
    localparam int c_AMP_BITS          = 8;
    localparam int c_SLEW_STEP_DEFAULT = 4;

    // Effective per-sample step of the amplitude slew limiter.
    // A step of 0 means "no slewing": that is the same as allowing the full
    // amplitude range in a single sample, so it maps to the largest
    // representable step. Steps larger than the range are clamped as well.
    function automatic int clamp_step(input int step, input int amp_bits);
        int max_step;
        max_step = (1 << amp_bits) - 1;
        if ((step <= 0) || (step > max_step)) begin
            return max_step;
        end
        return step;
    endfunction

endpackage : envelope_vca_pkg
`default_nettype wire

// File: rtl/envelope_vca_amp_slew_limiter.sv
`default_nettype none
// ============================================================================
//  Module      : envelope_vca_amp_slew_limiter
//  Description : Combinational next-value function of a slew-limited level.
//                Moves i_current toward i_target by at most SLEW_STEP, never
//                overshooting the target and never wrapping. SLEW_STEP = 0
//                makes the output follow the target immediately. Usable for
//                any unsigned control level (amplitude, filter cutoff, ...).
//  Ports       : i_target   in  AMP_BITS  level being approached
//                i_current  in  AMP_BITS  present level
//                o_next     out AMP_BITS  level after one step
//  Revision    : 1.0 - initial release
// ============================================================================
module envelope_vca_amp_slew_limiter
    import envelope_vca_pkg::*;
#(
    parameter int AMP_BITS  = c_AMP_BITS,
    parameter int SLEW_STEP = c_SLEW_STEP_DEFAULT
) (
    input  logic [AMP_BITS-1:0] i_target,
    input  logic [AMP_BITS-1:0] i_current,
    output logic [AMP_BITS-1:0] o_next
);

    localparam int                  c_STEP_INT = clamp_step(SLEW_STEP, AMP_BITS);
    localparam logic [AMP_BITS-1:0] c_STEP     = AMP_BITS'(c_STEP_INT);

    logic [AMP_BITS-1:0] w_rise;
    logic [AMP_BITS-1:0] w_fall;

    // Both distances are only meaningful in the branch that selects them;
    // the wrapped value in the other direction is never used.
    assign w_rise = i_target - i_current;
    assign w_fall = i_current - i_target;

    // The applied increment is min(step, distance), so the sum/difference can
    // neither pass the target nor leave the 0 .. 2^AMP_BITS-1 range.
    always_comb begin
        o_next = i_current;
        if (i_target > i_current) begin
            o_next = i_current + ((w_rise > c_STEP) ? c_STEP : w_rise);
        end else if (i_target < i_current) begin
            o_next = i_current - ((w_fall > c_STEP) ? c_STEP : w_fall);
        end
    end

endmodule : envelope_vca_amp_slew_limiter
`default_nettype wire

// File: rtl/envelope_vca.sv
`default_nettype none
// ============================================================================
//  Module      : envelope_vca
//  Description : Voltage-controlled amplifier following the ADSR envelope.
//                Each accepted signed tone sample is multiplied by a slewed
//                copy of the envelope amplitude and rounded back to the sample
//                width. Two-stage pipeline with valid/ready on both sides:
//                  stage 1 : register sample, step amp_cur toward amplitude
//                  stage 2 : gain = amp_cur + amp_cur[MSB] (255 -> 256),
//                            out = (sample * gain + 2^(AMP_BITS-1)) >>> AMP_BITS
//                Both stages advance together whenever the output register is
//                empty or being consumed, giving full throughput and a
//                two-cycle accept-to-output latency.
//  Ports       : clk         in  1            system clock
//                rst_n       in  1            synchronous active-low reset
//                in_sample   in  SAMPLE_BITS  signed tone sample
//                in_valid    in  1            in_sample valid
//                in_ready    out 1            sample accepted this cycle
//                amplitude   in  AMP_BITS     envelope amplitude (on accept)
//                out_sample  out SAMPLE_BITS  signed scaled sample
//                out_valid   out 1            out_sample valid
//                out_ready   in  1            downstream accepts out_sample
//  Revision    : 1.0 - initial release
// ============================================================================
module envelope_vca
    import envelope_vca_pkg::*;
#(
    parameter int SAMPLE_BITS = c_SAMPLE_BITS,
    parameter int AMP_BITS    = c_AMP_BITS,
    parameter int SLEW_STEP   = c_SLEW_STEP_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [SAMPLE_BITS-1:0] in_sample,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic        [AMP_BITS-1:0]    amplitude,
    output logic signed [SAMPLE_BITS-1:0] out_sample,
    output logic                          out_valid,
    input  logic                          out_ready
);

    // One guard bit for the unsigned gain and one for the product sign keep
    // the intermediate wide enough for any sample times a gain up to 2^AMP_BITS.
    localparam int c_PROD_BITS = SAMPLE_BITS + AMP_BITS + 2;

    // Half an output LSB, added before the arithmetic shift so that the
    // rounding is half toward +inf.
    localparam logic signed [c_PROD_BITS-1:0] c_ROUND =
        c_PROD_BITS'(1) << (AMP_BITS - 1);

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic w_adv;
    logic w_accept;

    logic                          r_out_valid;
    logic signed [SAMPLE_BITS-1:0] r_out_sample;

    assign w_adv    = !r_out_valid || out_ready;
    assign w_accept = in_valid && w_adv;
    assign in_ready = w_adv;

    assign out_valid  = r_out_valid;
    assign out_sample = r_out_sample;

    // ------------------------------------------------------------------------
    // Stage 1: sample register and slewed amplitude
    // ------------------------------------------------------------------------
    logic                          r_s1_valid;
    logic signed [SAMPLE_BITS-1:0] r_s1_sample;
    logic        [AMP_BITS-1:0]    r_amp_cur;
    logic        [AMP_BITS-1:0]    w_amp_next;

    envelope_vca_amp_slew_limiter #(
        .AMP_BITS  (AMP_BITS),
        .SLEW_STEP (SLEW_STEP)
    ) u_amp_slew (
        .i_target  (amplitude),
        .i_current (r_amp_cur),
        .o_next    (w_amp_next)
    );

    // ------------------------------------------------------------------------
    // Stage 2 datapath: gain mapping, multiply, round
    // ------------------------------------------------------------------------
    logic        [AMP_BITS:0]      w_gain;
    logic signed [c_PROD_BITS-1:0] w_sample_ext;
    logic signed [c_PROD_BITS-1:0] w_gain_ext;
    logic signed [c_PROD_BITS-1:0] w_prod;
    logic signed [c_PROD_BITS-1:0] w_rounded;
    logic signed [SAMPLE_BITS-1:0] w_scaled;

    // Adding the MSB stretches 0..2^AMP_BITS-1 onto 0..2^AMP_BITS with both
    // endpoints exact: full amplitude is true unity gain, zero is true silence.
    assign w_gain = {1'b0, r_amp_cur} + {{AMP_BITS{1'b0}}, r_amp_cur[AMP_BITS-1]};

    // Sample is sign-extended, gain is zero-extended (it is never negative).
    assign w_sample_ext = c_PROD_BITS'(r_s1_sample);
    assign w_gain_ext   = c_PROD_BITS'(w_gain);
    assign w_prod       = w_sample_ext * w_gain_ext;
    assign w_rounded    = w_prod + c_ROUND;

    // With |gain| <= 2^AMP_BITS the shifted result always fits the sample
    // width, so truncation loses nothing and no saturation stage is needed.
    assign w_scaled = SAMPLE_BITS'(w_rounded >>> AMP_BITS);

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    // amp_cur only moves on an accepted sample, so amplitude changes while
    // stalled or idle have no effect until the next sample is taken. Stage 2
    // reads stage 1 before it is overwritten, so a sample always leaves with
    // the amplitude value computed when it was accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sample  <= '0;
            r_amp_cur    <= '0;
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_sample <= in_sample;
                r_amp_cur   <= w_amp_next;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sample <= w_scaled;
            end
        end
    end

endmodule : envelope_vca
`default_nettype wire

// File: tb/tb_envelope_vca.sv
`default_nettype none
// ============================================================================
//  Module      : tb_envelope_vca
//  Description : Self-checking bench for envelope_vca. Two instances (no slew
//                and slew step 4) share one input stream; a queue-based model
//                predicts when each output appears and what it must be.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_envelope_vca;

    localparam int c_SB = 16;
    localparam int c_AB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic signed [c_SB-1:0] in_sample;
    logic                   in_valid;
    logic        [c_AB-1:0] amplitude;
    logic                   out_ready;

    logic                   in_ready0, in_ready4;
    logic                   out_valid0, out_valid4;
    logic signed [c_SB-1:0] out_sample0, out_sample4;

    envelope_vca #(.SAMPLE_BITS(c_SB), .AMP_BITS(c_AB), .SLEW_STEP(0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready0),
        .amplitude  (amplitude),
        .out_sample (out_sample0),
        .out_valid  (out_valid0),
        .out_ready  (out_ready)
    );

    envelope_vca #(.SAMPLE_BITS(c_SB), .AMP_BITS(c_AB), .SLEW_STEP(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready4),
        .amplitude  (amplitude),
        .out_sample (out_sample4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int t;
        int e0;
        int e4;
    } pend_t;

    pend_t exp_q[$];
    int    got0_q[$];
    int    got4_q[$];
    int    m_amp0 = 0;
    int    m_amp4 = 0;
    bit    rst_seen = 1'b0;
    int    slew_seq[11];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Slewed amplitude: move toward the target by at most step, 0 = jump.
    function automatic int slew(input int cur, input int tgt, input int step);
        if (step == 0) return tgt;
        if (tgt > cur) return (tgt - cur > step) ? cur + step : tgt;
        if (tgt < cur) return (cur - tgt > step) ? cur - step : tgt;
        return cur;
    endfunction

    // floor((s * gain + 128) / 256) with gain 0..256.
    function automatic int scale(input int s, input int a);
        int g;
        int p;
        g = (a >= 128) ? a + 1 : a;
        p = s * g + 128;
        if (p >= 0) return p / 256;
        return -((-p + 255) / 256);
    endfunction

    // ------------------------------------------------------------------------
    // Model and compare, once per cycle between edges
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        bit m_valid;
        pend_t front;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            m_amp0   = 0;
            m_amp4   = 0;
            rst_seen = 1'b1;
        end else begin
            if (rst_seen) begin
                check("reset_out_valid0", out_valid0, 0);
                check("reset_out_valid4", out_valid4, 0);
                check("reset_out_sample0", out_sample0, 0);
                check("reset_out_sample4", out_sample4, 0);
                check("reset_in_ready", in_ready0, 1);
                rst_seen = 1'b0;
            end
            // The oldest pending sample is presented from two cycles after
            // its accept until it is consumed; nothing is presented otherwise.
            m_valid = (exp_q.size() > 0) && (cyc - exp_q[0].t >= 2);
            check("out_valid0", out_valid0, m_valid);
            check("out_valid4", out_valid4, m_valid);
            check("in_ready0", in_ready0, !m_valid || out_ready);
            check("in_ready4", in_ready4, !m_valid || out_ready);
            if (m_valid) begin
                front = exp_q[0];
                check("out_sample0", out_sample0, front.e0);
                check("out_sample4", out_sample4, front.e4);
                if (out_ready) begin
                    got0_q.push_back(int'(out_sample0));
                    got4_q.push_back(int'(out_sample4));
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && (!m_valid || out_ready)) begin
                pend_t it;
                m_amp0 = slew(m_amp0, int'(amplitude), 0);
                m_amp4 = slew(m_amp4, int'(amplitude), 4);
                it.t  = cyc;
                it.e0 = scale(int'(in_sample), m_amp0);
                it.e4 = scale(int'(in_sample), m_amp4);
                exp_q.push_back(it);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input int s);
        in_sample = c_SB'(s);
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic clear_got();
        got0_q.delete();
        got4_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        amplitude = '0;
        out_ready = 1'b1;
        slew_seq  = '{4, 8, 12, 16, 20, 20, 16, 12, 8, 4, 2};
        repeat (2) tick();
        rst_n = 1'b1;

        // Full scale at unity gain; slewed instance starts from gain 4.
        clear_got();
        amplitude = 8'd255;
        send(32767);
        send(-32768);
        drain();
        check("unity_count", got0_q.size(), 2);
        check("unity_pos", got0_q[0], 32767);
        check("unity_neg", got0_q[1], -32768);
        check("slew_first_pos", got4_q[0], 512);
        check("slew_first_neg", got4_q[1], -1024);

        // Half-scale amplitude (gain 129) and rounding.
        clear_got();
        amplitude = 8'd128;
        send(1000);
        send(-1000);
        send(1);
        drain();
        check("half_count", got0_q.size(), 3);
        check("half_pos", got0_q[0], 504);
        check("half_neg", got0_q[1], -504);
        check("half_one", got0_q[2], 1);

        // Slew up to 20 then down to 2 from a fresh reset.
        do_reset(1);
        clear_got();
        amplitude = 8'd20;
        repeat (6) send(256);
        amplitude = 8'd2;
        repeat (5) send(256);
        drain();
        check("slew_count", got4_q.size(), 11);
        for (int i = 0; i < 11; i++) begin
            check("slew_seq4", got4_q[i], slew_seq[i]);
            check("slew_seq0", got0_q[i], (i < 6) ? 20 : 2);
        end

        // Backpressure: 5 stalled cycles with changing sample and amplitude.
        clear_got();
        amplitude = 8'd50;
        send(100);
        send(200);
        send(300);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_sample = c_SB'(1000 + i * 37);
            amplitude = c_AB'(60 + i * 30);
            @(negedge clk);
            check("stall_in_ready0", in_ready0, 0);
            check("stall_in_ready4", in_ready4, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        tick();
        send(2000);
        send(-2000);
        drain();
        check("bp_count", got0_q.size(), 6);
        check("bp_0", got0_q[0], 20);
        check("bp_1", got0_q[1], 39);
        check("bp_2", got0_q[2], 59);
        check("bp_3", got0_q[3], 812);
        check("bp_4", got0_q[4], 1414);
        check("bp_5", got0_q[5], -1414);

        // Reset with two samples in flight, then first sample at amplitude 255.
        amplitude = 8'd100;
        send(500);
        send(600);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        clear_got();
        amplitude = 8'd255;
        send(1000);
        drain();
        check("post_reset_count", got4_q.size(), 1);
        check("post_reset_slew", got4_q[0], 16);
        check("post_reset_unity", got0_q[0], 1000);

        // Zero amplitude silences everything exactly.
        do_reset(1);
        clear_got();
        amplitude = 8'd0;
        for (int i = 0; i < 20; i++) begin
            case (i % 4)
                0:       send(32767);
                1:       send(-32768);
                default: send(int'($signed(c_SB'($urandom))));
            endcase
        end
        drain();
        check("silence_count", got0_q.size(), 20);
        for (int i = 0; i < 20; i++) begin
            check("silence0", got0_q[i], 0);
            check("silence4", got4_q[i], 0);
        end

        // Random traffic, backpressure, amplitude jumps and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) amplitude = c_AB'($urandom);
            in_sample = c_SB'($urandom);
            rst_n     = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_envelope_vca
`default_nettype wire
